// File: rtl/common_p.sv
// Shared clock-domain bundle and flag mode encoding for control/status blocks.
package common_p;

    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_dom_s;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_STICKY = 2'b01,
        MODE_PULSE  = 2'b10,
        MODE_RSVD   = 2'b11
    } flag_mode_e;

    // Pulse counter width: enough to hold PULSE_CYCLES-1, never narrower than one bit.
    function automatic int unsigned pulse_cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/flag_channel.sv
// One flag bit with clear > set > toggle priority, per-channel mode, pulse timer and edge strobes.
module flag_channel
    import common_p::*;
#(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter logic        RESET_BIT    = 1'b0
) (
    input  clk_dom_s   clk_dom_s_i,
    input  logic       clear_en_i,
    input  logic       set_en_i,
    input  logic       toggle_en_i,
    input  flag_mode_e mode_i,
    output logic       state_o,
    output logic       rise_o,
    output logic       fall_o
);

    localparam int unsigned CNT_W = pulse_cnt_width(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

    logic             clk;
    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;
    logic             state_c;
    logic [CNT_W-1:0] cnt_c;
    logic             armed_c;

    assign clk = clk_dom_s_i.clk;

    // armed_q marks a pulse started by a trigger; a flag that is high only
    // because of reset never times out until it is re-triggered.
    always_comb begin
        state_c = state_o;
        cnt_c   = cnt_q;
        armed_c = armed_q;
        case (mode_i)
            MODE_STICKY: begin
                if (clear_en_i) begin
                    state_c = 1'b0;
                end else if (set_en_i) begin
                    state_c = 1'b1;
                end
            end
            MODE_PULSE: begin
                if (clear_en_i) begin
                    state_c = 1'b0;
                    cnt_c   = '0;
                end else if (set_en_i || (toggle_en_i && !state_o)) begin
                    state_c = 1'b1;
                    cnt_c   = CNT_LOAD;
                    armed_c = 1'b1;
                end else if (toggle_en_i) begin
                    state_c = 1'b0;
                    cnt_c   = '0;
                end else if (state_o && armed_q) begin
                    if (cnt_q != '0) begin
                        cnt_c = cnt_q - CNT_W'(1);
                    end else begin
                        state_c = 1'b0;
                    end
                end
            end
            default: begin
                if (clear_en_i) begin
                    state_c = 1'b0;
                end else if (set_en_i) begin
                    state_c = 1'b1;
                end else if (toggle_en_i) begin
                    state_c = ~state_o;
                end
            end
        endcase
        if (!state_c) begin
            armed_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_dom_s_i.sync_rst) begin
            state_o <= RESET_BIT;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (clk_dom_s_i.clk_en) begin
            state_o <= state_c;
            rise_o  <= state_c & ~state_o;
            fall_o  <= ~state_c & state_o;
            cnt_q   <= cnt_c;
            armed_q <= armed_c;
        end
    end

endmodule

// File: rtl/flag_bank.sv
// Bank of independent mode-selectable flags with per-channel strobes and aggregate any/popcount.
module flag_bank
    import common_p::*;
#(
    parameter int unsigned          CHANNELS     = 8,
    parameter logic [CHANNELS-1:0]  RESET_VALUE  = '0,
    parameter int unsigned          PULSE_CYCLES = 4
) (
    input  clk_dom_s                        clk_dom_s_i,
    input  logic       [CHANNELS-1:0]       clear_en_i,
    input  logic       [CHANNELS-1:0]       set_en_i,
    input  logic       [CHANNELS-1:0]       toggle_en_i,
    input  flag_mode_e                      mode_i [CHANNELS],
    output logic       [CHANNELS-1:0]       state_o,
    output logic       [CHANNELS-1:0]       rise_o,
    output logic       [CHANNELS-1:0]       fall_o,
    output logic                            any_o,
    output logic [$clog2(CHANNELS+1)-1:0]   active_count_o
);

    localparam int unsigned CNT_W = $clog2(CHANNELS + 1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        flag_channel #(
            .PULSE_CYCLES (PULSE_CYCLES),
            .RESET_BIT    (RESET_VALUE[g])
        ) u_ch (
            .clk_dom_s_i (clk_dom_s_i),
            .clear_en_i  (clear_en_i[g]),
            .set_en_i    (set_en_i[g]),
            .toggle_en_i (toggle_en_i[g]),
            .mode_i      (mode_i[g]),
            .state_o     (state_o[g]),
            .rise_o      (rise_o[g]),
            .fall_o      (fall_o[g])
        );
    end

    assign any_o = |state_o;

    // Population count of the registered state.
    always_comb begin
        active_count_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            active_count_o = active_count_o + CNT_W'(state_o[i]);
        end
    end

endmodule

// File: tb/tb_flag_bank.sv
// Directed self-checking bench for flag_bank: reset, clock enable, HOLD/STICKY/PULSE behaviour and reset abort.
module tb_flag_bank;
    import common_p::*;

    localparam int unsigned CH = 8;

    logic            clk = 1'b0;
    logic            clk_en = 1'b0;
    logic            sync_rst = 1'b0;
    clk_dom_s        cd;
    logic [CH-1:0]   clr = '0;
    logic [CH-1:0]   set = '0;
    logic [CH-1:0]   tog = '0;
    flag_mode_e      mode [CH];
    logic [CH-1:0]   state;
    logic [CH-1:0]   rise;
    logic [CH-1:0]   fall;
    logic            any;
    logic [3:0]      count;

    int checks = 0;
    int failures = 0;

    assign cd = '{clk: clk, clk_en: clk_en, sync_rst: sync_rst};

    always #5 clk = ~clk;

    flag_bank #(
        .CHANNELS     (CH),
        .RESET_VALUE  (8'hA5),
        .PULSE_CYCLES (4)
    ) dut (
        .clk_dom_s_i    (cd),
        .clear_en_i     (clr),
        .set_en_i       (set),
        .toggle_en_i    (tog),
        .mode_i         (mode),
        .state_o        (state),
        .rise_o         (rise),
        .fall_o         (fall),
        .any_o          (any),
        .active_count_o (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given enable; requests are one-shot.
    task automatic cyc(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
        clr = '0;
        set = '0;
        tog = '0;
        clk_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < CH; i++) mode[i] = MODE_HOLD;
        mode[5] = MODE_PULSE;

        // Reset, enable ignored
        sync_rst = 1'b1;
        cyc(1'b0);
        sync_rst = 1'b0;
        check("rst_state", 32'(state), 32'hA5);
        check("rst_rise", 32'(rise), 32'h0);
        check("rst_fall", 32'(fall), 32'h0);
        check("rst_any", 32'(any), 32'h1);
        check("rst_count", 32'(count), 32'd4);

        // Disabled edges ignore all requests
        for (int i = 0; i < 10; i++) begin
            clr = {CH{i[0]}};
            set = ~clr;
            tog = '1;
            cyc(1'b0);
        end
        check("cke_state", 32'(state), 32'hA5);
        check("cke_count", 32'(count), 32'd4);
        check("cke_strobes", 32'({rise, fall}), 32'h0);

        // HOLD ch0 (starts high)
        clr[0] = 1'b1; cyc(1'b1);
        check("hold_pre_clr", 32'(state[0]), 32'h0);
        set[0] = 1'b1; cyc(1'b1);
        check("hold_set", 32'({state[0], rise[0], fall[0]}), 32'b110);
        set[0] = 1'b1; clr[0] = 1'b1; cyc(1'b1);
        check("hold_setclr", 32'({state[0], rise[0], fall[0]}), 32'b001);
        tog[0] = 1'b1; cyc(1'b1);
        check("hold_tog", 32'({state[0], rise[0], fall[0]}), 32'b110);
        check("pulse_reset_high_no_autoclr", 32'(state[5]), 32'h1);

        // STICKY ch1
        mode[1] = MODE_STICKY;
        set[1] = 1'b1; cyc(1'b1);
        check("sticky_set", 32'({state[1], rise[1], fall[1]}), 32'b110);
        for (int i = 0; i < 3; i++) begin
            tog[1] = 1'b1; cyc(1'b1);
            check("sticky_tog", 32'({state[1], rise[1], fall[1]}), 32'b100);
        end
        clr[1] = 1'b1; cyc(1'b1);
        check("sticky_clr", 32'({state[1], rise[1], fall[1]}), 32'b001);

        // PULSE ch2, clk_en at 50% duty
        clr[2] = 1'b1; cyc(1'b1);
        mode[2] = MODE_PULSE;
        set[2] = 1'b1; cyc(1'b1);
        check("pulse_e0", 32'({state[2], rise[2]}), 32'b11);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0);
            if (k == 1) check("pulse_rise_held", 32'(rise[2]), 32'h1);
            cyc(1'b1);
            check("pulse_state", 32'(state[2]), 32'(k < 4));
            check("pulse_fall", 32'(fall[2]), 32'(k == 4));
        end
        cyc(1'b0);
        check("pulse_fall_held", 32'(fall[2]), 32'h1);

        // Retrigger at enabled cycle 3
        set[2] = 1'b1; cyc(1'b1);
        check("retrig_e0", 32'({state[2], rise[2]}), 32'b11);
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b0);
            if (k == 3) set[2] = 1'b1;
            cyc(1'b1);
            check("retrig_state", 32'(state[2]), 32'(k < 7));
            check("retrig_rise", 32'(rise[2]), 32'h0);
            check("retrig_fall", 32'(fall[2]), 32'(k == 7));
        end

        // PULSE ch3 frozen by HOLD, then resumed
        mode[3] = MODE_PULSE;
        set[3] = 1'b1; cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        mode[3] = MODE_HOLD;
        for (int i = 0; i < 10; i++) cyc(1'b1);
        check("freeze_high", 32'(state[3]), 32'h1);
        mode[3] = MODE_PULSE;
        cyc(1'b1);
        check("resume_1", 32'(state[3]), 32'h1);
        cyc(1'b1);
        check("resume_2", 32'({state[3], fall[3]}), 32'b01);

        // Reset aborts an active pulse
        mode[4] = MODE_PULSE;
        set[4] = 1'b1; cyc(1'b1);
        check("abort_rise", 32'({state[4], rise[4]}), 32'b11);
        sync_rst = 1'b1;
        tog = '1;
        set = '1;
        cyc(1'b0);
        sync_rst = 1'b0;
        check("abort_state", 32'(state), 32'hA5);
        check("abort_strobes", 32'({rise, fall}), 32'h0);
        for (int i = 0; i < 6; i++) cyc(1'b1);
        check("post_rst_state", 32'(state), 32'hA5);
        check("post_rst_strobes", 32'({rise, fall}), 32'h0);

        // Clear everything
        clr = '1; cyc(1'b1);
        check("all_clr_state", 32'(state), 32'h0);
        check("all_clr_any", 32'(any), 32'h0);
        check("all_clr_count", 32'(count), 32'h0);
        check("all_clr_fall", 32'(fall), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
